// File: rtl/rs_issue_scheduler_if.sv
// Dispatch/issue bus between the reservation-station bank, dispatch logic and the FU.
// The master drives the RS status and handshakes, and the slave is the scheduler.
interface rs_issue_scheduler_if #(
    parameter int NUM_RS       = 4,
    parameter int ROB_TAG_BITS = 5,
    parameter int IDX_BITS     = $clog2(NUM_RS)
);
    logic                           dispatch_valid;
    logic [NUM_RS-1:0]              rs_avail;
    logic [NUM_RS-1:0]              rs_ready;
    logic [NUM_RS*ROB_TAG_BITS-1:0] rs_tag;
    logic                           fu_ready;
    logic                           rob_clear;
    logic [NUM_RS-1:0]              rs_load;
    logic                           dispatch_stall;
    logic                           issue_valid;
    logic [IDX_BITS-1:0]            issue_idx;
    logic [ROB_TAG_BITS-1:0]        issue_tag;
    logic [NUM_RS-1:0]              rs_free;

    modport master (
        output dispatch_valid, rs_avail, rs_ready, rs_tag, fu_ready, rob_clear,
        input  rs_load, dispatch_stall, issue_valid, issue_idx, issue_tag, rs_free
    );

    modport slave (
        input  dispatch_valid, rs_avail, rs_ready, rs_tag, fu_ready, rob_clear,
        output rs_load, dispatch_stall, issue_valid, issue_idx, issue_tag, rs_free
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Reservation-station allocator plus round-robin issue scheduler for one shared FU.
// Define RS_SCHED_PERF_EN to add saturating issue/stall performance counters.
module rs_issue_scheduler #(
    parameter int NUM_RS       = 4,
    parameter int ROB_TAG_BITS = 5,
    parameter int IDX_BITS     = $clog2(NUM_RS)
) (
    input  logic                  clock,
    input  logic                  reset,
    rs_issue_scheduler_if.slave   bus
`ifdef RS_SCHED_PERF_EN
    ,
    output logic [15:0]           perf_issue_cnt,
    output logic [15:0]           perf_stall_cnt
`endif
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t                  state, state_next;
    logic [IDX_BITS-1:0]     rr_ptr;
    logic [NUM_RS-1:0]       alloc_pend;
    logic                    issue_valid_q;
    logic [IDX_BITS-1:0]     issue_idx_q;
    logic [ROB_TAG_BITS-1:0] issue_tag_q;

    logic [NUM_RS-1:0]       held_mask, cand, elig, load_mask, free_mask;
    logic                    stall, handshake, take_issue, win_found;
    logic [IDX_BITS-1:0]     win_idx, probe;
    logic [ROB_TAG_BITS-1:0] win_tag;

    assign held_mask = issue_valid_q ? (NUM_RS'(1) << issue_idx_q) : '0;
    assign cand      = bus.rs_avail & ~alloc_pend & ~held_mask;
    assign elig      = bus.rs_ready & ~bus.rs_avail & ~held_mask;

    // Round-robin search over eligible slots starting at rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        probe     = rr_ptr;
        for (int k = 0; k < NUM_RS; k++) begin
            probe = rr_ptr + IDX_BITS'(k);
            if (!win_found && elig[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    assign win_tag = bus.rs_tag[win_idx*ROB_TAG_BITS +: ROB_TAG_BITS];

    always_comb begin
        state_next = state;
        load_mask  = '0;
        free_mask  = '0;
        stall      = 1'b1;
        handshake  = 1'b0;
        take_issue = 1'b0;
        case (state)
            RUN: begin
                if (bus.rob_clear) begin
                    state_next = FLUSH;
                end else begin
                    stall      = (cand == '0);
                    load_mask  = bus.dispatch_valid ? (cand & (~cand + NUM_RS'(1))) : '0;
                    handshake  = issue_valid_q && bus.fu_ready;
                    free_mask  = handshake ? held_mask : '0;
                    take_issue = !issue_valid_q || bus.fu_ready;
                end
            end
            FLUSH: begin
                free_mask  = '1;
                state_next = bus.rob_clear ? FLUSH : RUN;
            end
            default: state_next = RUN;
        endcase
        // Outputs must go quiet the instant reset asserts, not at the next edge.
        if (!reset) begin
            load_mask = '0;
            stall     = 1'b1;
            free_mask = '0;
            handshake = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            rr_ptr        <= '0;
            alloc_pend    <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            issue_tag_q   <= '0;
        end else begin
            state      <= state_next;
            alloc_pend <= load_mask;
            if (state == FLUSH || bus.rob_clear) begin
                issue_valid_q <= 1'b0;
                rr_ptr        <= '0;
            end else if (take_issue) begin
                issue_valid_q <= win_found;
                if (win_found) begin
                    issue_idx_q <= win_idx;
                    issue_tag_q <= win_tag;
                    rr_ptr      <= win_idx + IDX_BITS'(1);
                end
            end
        end
    end

`ifdef RS_SCHED_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (handshake && perf_issue_cnt != 16'hFFFF)
                perf_issue_cnt <= perf_issue_cnt + 16'd1;
            if (bus.dispatch_valid && stall && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

    assign bus.rs_load        = load_mask;
    assign bus.dispatch_stall = stall;
    assign bus.issue_valid    = issue_valid_q;
    assign bus.issue_idx      = issue_idx_q;
    assign bus.issue_tag      = issue_tag_q;
    assign bus.rs_free        = free_mask;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Randomized bench for rs_issue_scheduler, checked against a cycle-level behavioural model.
// The model tracks the scheduler's visible state as plain ints and bit arrays.
module tb_rs_issue_scheduler;

    localparam int NRS = 4;
    localparam int TB  = 5;
    localparam int IB  = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    rs_issue_scheduler_if #(.NUM_RS(NRS), .ROB_TAG_BITS(TB), .IDX_BITS(IB)) bus ();

`ifdef RS_SCHED_PERF_EN
    logic [15:0] perf_issue_cnt, perf_stall_cnt;
`endif

    rs_issue_scheduler #(.NUM_RS(NRS), .ROB_TAG_BITS(TB), .IDX_BITS(IB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef RS_SCHED_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    bit       m_flush;
    int       m_rr;
    bit [3:0] m_pend;
    bit       m_valid;
    int       m_idx;
    int       m_tag;
    int       m_issue_cnt;
    int       m_stall_cnt;
    int       tags [NRS];
    bit [3:0] last_free;
    bit [3:0] ready;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_flush = 0; m_rr = 0; m_pend = 0; m_valid = 0;
        m_idx = 0; m_tag = 0; m_issue_cnt = 0; m_stall_cnt = 0;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic computeExpected(output bit [3:0] e_load, output bit e_stall, output bit [3:0] e_free);
        bit [3:0] c;
        bit       got;
        e_load = 0; e_stall = 1; e_free = 0; c = 0; got = 0;
        if (reset === 1'b1) begin
            if (m_flush) begin
                e_free = 4'hF;
            end else if (!bus.rob_clear) begin
                for (int i = 0; i < NRS; i++)
                    if (bus.rs_avail[i] && !m_pend[i] && !(m_valid && m_idx == i)) c[i] = 1;
                e_stall = (c == 0);
                for (int i = 0; i < NRS; i++)
                    if (bus.dispatch_valid && c[i] && !got) begin e_load[i] = 1; got = 1; end
                if (m_valid && bus.fu_ready) e_free[m_idx] = 1;
            end
        end
    endtask

    task automatic checkAll(input string ctx);
        bit [3:0] el, ef;
        bit       es;
        computeExpected(el, es, ef);
        last_free = ef;
        checkOutput({ctx, " rs_load"}, 32'(bus.rs_load), 32'(el));
        checkOutput({ctx, " dispatch_stall"}, 32'(bus.dispatch_stall), 32'(es));
        checkOutput({ctx, " rs_free"}, 32'(bus.rs_free), 32'(ef));
        checkOutput({ctx, " issue_valid"}, 32'(bus.issue_valid), 32'(m_valid));
        if (m_valid) begin
            checkOutput({ctx, " issue_idx"}, 32'(bus.issue_idx), 32'(m_idx));
            checkOutput({ctx, " issue_tag"}, 32'(bus.issue_tag), 32'(m_tag));
        end
`ifdef RS_SCHED_PERF_EN
        checkOutput({ctx, " perf_issue"}, 32'(perf_issue_cnt), (m_issue_cnt > 65535) ? 32'd65535 : 32'(m_issue_cnt));
        checkOutput({ctx, " perf_stall"}, 32'(perf_stall_cnt), (m_stall_cnt > 65535) ? 32'd65535 : 32'(m_stall_cnt));
`endif
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic modelEdge();
        bit [3:0] el, ef;
        bit       es, found;
        int       w, j;
        if (reset !== 1'b1) return;
        computeExpected(el, es, ef);
        if (bus.dispatch_valid && es) m_stall_cnt++;
        if (m_flush || bus.rob_clear) begin
            m_flush = bus.rob_clear;
            m_pend = 0; m_valid = 0; m_rr = 0;
        end else begin
            if (m_valid && bus.fu_ready) m_issue_cnt++;
            m_pend = el;
            if (!m_valid || bus.fu_ready) begin
                found = 0; w = 0;
                for (int k = 0; k < NRS; k++) begin
                    j = (m_rr + k) % NRS;
                    if (!found && bus.rs_ready[j] && !bus.rs_avail[j] && !(m_valid && m_idx == j)) begin
                        found = 1; w = j;
                    end
                end
                m_valid = found;
                if (found) begin
                    m_idx = w; m_tag = tags[w]; m_rr = (w + 1) % NRS;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit dv, input bit [3:0] avail, input bit [3:0] rdy, input bit fu, input bit clr);
        bus.dispatch_valid = dv;
        bus.rs_avail       = avail;
        bus.rs_ready       = rdy;
        bus.fu_ready       = fu;
        bus.rob_clear      = clr;
        for (int i = 0; i < NRS; i++) bus.rs_tag[i*TB +: TB] = TB'(tags[i]);
    endtask

    task automatic runCycle(input string ctx);
        #1 checkAll(ctx);
        @(posedge clock);
        modelEdge();
        @(negedge clock);
    endtask

    initial begin
        tags = '{3, 7, 9, 12};
        modelReset();
        applyStimulus(0, 4'h0, 4'h0, 0, 0);
        @(negedge clock);
        #1 checkAll("reset");
        @(negedge clock);
        reset = 1'b1;

        applyStimulus(1, 4'hF, 4'h0, 0, 0);
        runCycle("alloc0");
        runCycle("alloc1");
        applyStimulus(0, 4'hF, 4'h0, 0, 0);
        runCycle("alloc_idle");

        applyStimulus(1, 4'h0, 4'h0, 0, 0);
        repeat (3) runCycle("full_stall");

        ready = 4'hF;
        applyStimulus(0, 4'h0, ready, 1, 0);
        repeat (6) begin
            runCycle("b2b_issue");
            ready &= ~last_free;
            applyStimulus(0, 4'h0, ready, 1, 0);
        end

        applyStimulus(0, 4'h0, 4'b0100, 0, 0);
        repeat (4) runCycle("backpressure");
        applyStimulus(0, 4'h0, 4'b0100, 1, 0);
        runCycle("bp_release");
        applyStimulus(0, 4'h0, 4'h0, 1, 0);
        runCycle("bp_after");

        applyStimulus(0, 4'h0, 4'b0010, 1, 0);
        runCycle("pre_clear");
        applyStimulus(1, 4'h0, 4'b0010, 1, 1);
        runCycle("clear");
        applyStimulus(1, 4'hF, 4'h0, 1, 0);
        runCycle("flush");
        applyStimulus(0, 4'h0, 4'b1001, 1, 0);
        runCycle("post_flush0");
        runCycle("post_flush1");

        repeat (300) begin
            for (int i = 0; i < NRS; i++) tags[i] = int'($urandom_range(0, 31));
            applyStimulus(1'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 11) == 0));
            runCycle("random");
        end

        applyStimulus(0, 4'h0, 4'h0, 1, 0);
        runCycle("drain0");
        runCycle("drain1");
        applyStimulus(1, 4'b1011, 4'b0100, 0, 0);
        runCycle("hold0");
        runCycle("hold1");
        #2 reset = 1'b0;
        modelReset();
        #1 checkAll("async_reset");
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(0, 4'h0, 4'h0, 0, 0);
        runCycle("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
